cache_axi_arbiter: RTL and testbench

Shares the single AXI read-address/read-data channel between the instruction cache and the data cache. Each granted transaction keeps ownership of the channel until its last data beat. The block also snoops the data cache's write channel, which stays point-to-point at top level. It holds instruction-line refills that target a line whose dirty write-back has not yet completed.

---
 rtl/cache_arb_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/cache_axi_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared encodings for the I/D-cache AXI read arbiter: FSM states, default
// read IDs and grant polarity.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wstate_t;

    localparam int INST_ARID = 0;
    localparam int DATA_ARID = 1;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. req[0] is the I-cache, req[1] the D-cache;
// on a tie the side opposite the last completed owner wins.
module rr_arbiter2
    import cache_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       gnt
);

    logic last_grant;

    // History only moves when a transaction finishes, not when it is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GNT_INST;
        end else if (update) begin
            last_grant <= served;
        end
    end

    always_comb begin
        gnt = GNT_INST;
        if (req == 2'b11) begin
            gnt = ~last_grant;
        end else if (req[1]) begin
            gnt = GNT_DATA;
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI read channel between the I-cache and D-cache, and holds
// I-cache refills of a line whose D-cache write-back is still outstanding.
module cache_axi_arbiter
    import cache_arb_pkg::*;
#(
    parameter int OFFSET_WIDTH = 5,
    parameter int ID_WIDTH     = 4,
    parameter int INST_ID      = INST_ARID,
    parameter int DATA_ID      = DATA_ARID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic                i_rvalid,
    input  logic                i_rready,
    input  logic [31:0]         d_araddr,
    input  logic [7:0]          d_arlen,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic                d_rvalid,
    input  logic                d_rready,
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic                arvalid,
    input  logic                arready,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    input  logic [31:0]         awaddr,
    input  logic                awvalid,
    input  logic                awready,
    input  logic                bvalid,
    input  logic                bready
);

    localparam int LINE_W = 32 - OFFSET_WIDTH;

    rstate_t           rstate;
    rstate_t           rnext;
    wstate_t           wstate;
    wstate_t           wnext;
    logic              g;
    logic              gnt;
    logic              grant_load;
    logic              arb_update;
    logic              wline_load;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] iline;
    logic [LINE_W-1:0] awline;
    logic              aw_hs;
    logic              b_hs;
    logic              hazard;
    logic              i_cand;
    logic              d_cand;
    logic              unused_ok;

    assign iline     = i_araddr[31:OFFSET_WIDTH];
    assign awline    = awaddr[31:OFFSET_WIDTH];
    assign unused_ok = &{1'b0, awaddr[OFFSET_WIDTH-1:0]};
    assign aw_hs     = awvalid && awready;
    assign b_hs      = bvalid && bready;

    // A write address still on the bus counts as in flight, so a refill cannot
    // slip past a write-back in the same cycle it is being issued.
    assign hazard = ((wstate == W_BUSY) && (iline == wline)) ||
                    (awvalid && (iline == awline));
    assign i_cand = i_arvalid && !hazard;
    assign d_cand = d_arvalid;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_cand, i_cand}),
        .update (arb_update),
        .served (g),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate <= R_IDLE;
            g      <= GNT_INST;
        end else begin
            rstate <= rnext;
            if (grant_load) begin
                g <= gnt;
            end
        end
    end

    always_comb begin
        rnext      = rstate;
        grant_load = 1'b0;
        arb_update = 1'b0;
        arvalid    = 1'b0;
        i_arready  = 1'b0;
        d_arready  = 1'b0;
        rready     = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        unique case (rstate)
            R_IDLE: begin
                if (i_cand || d_cand) begin
                    rnext      = R_ADDR;
                    grant_load = 1'b1;
                end
            end
            R_ADDR: begin
                arvalid   = g ? d_arvalid : i_arvalid;
                i_arready = !g && arready;
                d_arready = g && arready;
                if (arvalid && arready) begin
                    rnext = R_DATA;
                end
            end
            R_DATA: begin
                i_rvalid = !g && rvalid;
                d_rvalid = g && rvalid;
                rready   = g ? d_rready : i_rready;
                if (rvalid && rready && rlast) begin
                    rnext      = R_IDLE;
                    arb_update = 1'b1;
                end
            end
            default: rnext = R_IDLE;
        endcase
    end

    assign araddr = g ? d_araddr : i_araddr;
    assign arlen  = g ? d_arlen : i_arlen;
    assign arid   = g ? ID_WIDTH'(DATA_ID) : ID_WIDTH'(INST_ID);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate <= W_IDLE;
            wline  <= '0;
        end else begin
            wstate <= wnext;
            if (wline_load) begin
                wline <= awline;
            end
        end
    end

    // Only one write-back is tracked; a same-cycle B and AW retires the old
    // line and starts tracking the new one.
    always_comb begin
        wnext      = wstate;
        wline_load = 1'b0;
        unique case (wstate)
            W_IDLE: begin
                if (aw_hs) begin
                    wnext      = W_BUSY;
                    wline_load = 1'b1;
                end
            end
            W_BUSY: begin
                if (b_hs) begin
                    if (aw_hs) begin
                        wline_load = 1'b1;
                    end else begin
                        wnext = W_IDLE;
                    end
                end
            end
            default: wnext = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: stimulus pushes expected AR requests
// and beat routing into queues, a negedge monitor pops and compares them.
module tb_cache_axi_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic        i_rvalid;
    logic        i_rready;
    logic [31:0] d_araddr;
    logic [7:0]  d_arlen;
    logic        d_arvalid;
    logic        d_arready;
    logic        d_rvalid;
    logic        d_rready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    logic [63:0] ar_q[$];
    logic [1:0]  beat_q[$];

    cache_axi_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_araddr  (i_araddr),
        .i_arlen   (i_arlen),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .d_araddr  (d_araddr),
        .d_arlen   (d_arlen),
        .d_arvalid (d_arvalid),
        .d_arready (d_arready),
        .d_rvalid  (d_rvalid),
        .d_rready  (d_rready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arvalid   (arvalid),
        .arready   (arready),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void check_output(input string name, input logic [63:0] act,
                                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected AR fields are {arid, araddr, arlen}; beats are {i_rvalid, d_rvalid}.
    task automatic apply_stimulus(input bit side, input logic [31:0] addr, input int len);
        ar_q.push_back({20'd0, (side ? 4'd1 : 4'd0), addr, 8'(len)});
        for (int b = 0; b <= len; b++) begin
            beat_q.push_back(side ? 2'b01 : 2'b10);
        end
        if (side) begin
            d_araddr  = addr;
            d_arlen   = 8'(len);
            d_arvalid = 1'b1;
        end else begin
            i_araddr  = addr;
            i_arlen   = 8'(len);
            i_arvalid = 1'b1;
        end
    endtask

    // Slave side: accept the address after 'delay' cycles, stream len+1 beats.
    // hook_kind 1 raises a D request at hook_beat; 2 resets at hook_beat.
    task automatic serve_read(input bit side, input logic [31:0] addr, input int len,
                              input int delay, input int hook_beat, input int hook_kind);
        int n = 0;
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        if (!arvalid) begin
            check_output("ar_wait_timeout", 64'(arvalid), 64'd1);
            return;
        end
        for (int k = 0; k < delay; k++) begin
            check_output("ar_hold_valid", 64'(arvalid), 64'd1);
            check_output("ar_hold_addr", 64'(araddr), 64'(addr));
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        if (side) d_arvalid = 1'b0;
        else      i_arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            rvalid = 1'b1;
            rlast  = (b == len);
            if (hook_kind == 1 && b == hook_beat) begin
                apply_stimulus(1'b1, 32'h0000_5000, 1);
            end
            if (hook_kind == 1 && b >= hook_beat) begin
                @(negedge clk);
                check_output("d_arready_blocked", 64'(d_arready), 64'd0);
            end
            if (hook_kind == 2 && b == hook_beat) begin
                #2 rst = 1'b0;
                #1;
                check_output("rst_rready", 64'(rready), 64'd0);
                check_output("rst_d_rvalid", 64'(d_rvalid), 64'd0);
                check_output("rst_arvalid", 64'(arvalid), 64'd0);
                rvalid = 1'b0;
                rlast  = 1'b0;
                beat_q.delete();
                tick();
                rst = 1'b1;
                return;
            end
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check_output(name, {62'd0, arvalid, rready}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    check_output("ar_unexpected", {20'd0, arid, araddr, arlen}, 64'd0);
                end else begin
                    check_output("ar_fields", {20'd0, arid, araddr, arlen}, ar_q.pop_front());
                end
            end
            if (rvalid && rready) begin
                if (beat_q.size() == 0) begin
                    check_output("beat_unexpected", {62'd0, i_rvalid, d_rvalid}, 64'd0);
                end else begin
                    check_output("beat_route", {62'd0, i_rvalid, d_rvalid}, 64'(beat_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b1;
        d_araddr = '0; d_arlen = '0; d_arvalid = 1'b0; d_rready = 1'b1;
        arready = 1'b0; rlast = 1'b0; rvalid = 1'b0;
        awaddr = '0; awvalid = 1'b0; awready = 1'b0; bvalid = 1'b0; bready = 1'b0;

        repeat (3) tick();
        check_output("reset_outputs",
                     {58'd0, arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid}, 64'd0);
        rst = 1'b1;
        tick();

        $display("[TB] inst-only refill");
        apply_stimulus(1'b0, 32'hBFC0_0020, 7);
        @(negedge clk);
        check_output("grant_latency_pre", 64'(arvalid), 64'd0);
        tick();
        check_output("grant_latency_post", 64'(arvalid), 64'd1);
        serve_read(1'b0, 32'hBFC0_0020, 7, 0, -1, 0);
        check_idle("idle_after_inst");

        $display("[TB] simultaneous requests and round robin");
        apply_stimulus(1'b1, 32'h0000_2000, 1);
        apply_stimulus(1'b0, 32'h0000_1000, 3);
        serve_read(1'b1, 32'h0000_2000, 1, 0, -1, 0);
        check_idle("idle_after_data_rr");
        apply_stimulus(1'b1, 32'h0000_3000, 0);
        serve_read(1'b0, 32'h0000_1000, 3, 0, -1, 0);
        serve_read(1'b1, 32'h0000_3000, 0, 0, -1, 0);
        check_idle("idle_after_rr");

        $display("[TB] data request during inst burst");
        apply_stimulus(1'b0, 32'h0000_4000, 7);
        serve_read(1'b0, 32'h0000_4000, 7, 0, 3, 1);
        check_output("data_after_rlast_pre", 64'(arvalid), 64'd0);
        tick();
        check_output("data_after_rlast_post", 64'(arvalid), 64'd1);
        serve_read(1'b1, 32'h0000_5000, 1, 0, -1, 0);
        check_idle("idle_after_overlap");

        $display("[TB] write-back hazard");
        awaddr = 32'h8000_1000; awvalid = 1'b1; awready = 1'b1;
        tick();
        awvalid = 1'b0; awready = 1'b0;
        apply_stimulus(1'b0, 32'h8000_1010, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("hazard_hold", 64'(arvalid), 64'd0);
        end
        bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0; bready = 1'b0;
        check_output("hazard_release_pre", 64'(arvalid), 64'd0);
        tick();
        check_output("hazard_release_post", 64'(arvalid), 64'd1);
        serve_read(1'b0, 32'h8000_1010, 3, 0, -1, 0);
        check_idle("idle_after_hazard");

        awaddr = 32'h8000_1000; awvalid = 1'b1; awready = 1'b1;
        tick();
        awvalid = 1'b0; awready = 1'b0;
        apply_stimulus(1'b0, 32'h8000_2000, 1);
        tick();
        check_output("no_hazard_other_line", 64'(arvalid), 64'd1);
        serve_read(1'b0, 32'h8000_2000, 1, 0, -1, 0);
        bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0; bready = 1'b0;

        awaddr = 32'h8000_3000; awvalid = 1'b1;
        apply_stimulus(1'b0, 32'h8000_3004, 0);
        repeat (2) begin
            tick();
            check_output("aw_pending_hazard", 64'(arvalid), 64'd0);
        end
        awvalid = 1'b0;
        tick();
        tick();
        check_output("aw_dropped_grant", 64'(arvalid), 64'd1);
        serve_read(1'b0, 32'h8000_3004, 0, 0, -1, 0);

        $display("[TB] uncached data read with slow arready");
        apply_stimulus(1'b1, 32'h1FAF_0000, 0);
        serve_read(1'b1, 32'h1FAF_0000, 0, 3, -1, 0);
        check_idle("idle_after_uncached");

        $display("[TB] reset mid data burst");
        apply_stimulus(1'b1, 32'h0000_7000, 7);
        serve_read(1'b1, 32'h0000_7000, 7, 0, 4, 2);
        check_idle("idle_after_reset");
        apply_stimulus(1'b0, 32'h0000_6000, 1);
        serve_read(1'b0, 32'h0000_6000, 1, 0, -1, 0);
        check_idle("idle_after_recovery");

        repeat (2) tick();
        check_output("ar_queue_drained", 64'(ar_q.size()), 64'd0);
        check_output("beat_queue_drained", 64'(beat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
